// File: rtl/mrd_bank_reader.sv
// Read side of the 7-bank mixed-radix DFT memory: streams a frame back out in
// natural or radix-7 transposed order and absorbs the RAM read latency.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | waiting for start with rows != 0
//  READ    | one bank read per cycle until bank 6 / row M-1 has been issued
//  DRAIN   | RD_LAT+1 cycles letting the last read leave the pipeline
module mrd_bank_reader #(
    parameter int wADDR  = 8,
    parameter int wDATA  = 32,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [wADDR:0]        rows,
    input  logic                  mode,
    output logic [wADDR-1:0]      rdaddr,
    output logic [6:0]            rden,
    input  logic [6:0][wDATA-1:0] rddata,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [wDATA-1:0]      out_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int               wDRN     = $clog2(RD_LAT + 1) + 1;
    localparam logic [wDRN-1:0]  DRN_LAST = wDRN'(RD_LAT);

    logic [1:0]                state_q, state_d;
    logic [wADDR:0]            rows_q, rows_d;
    logic                      mode_q, mode_d;
    logic [wADDR:0]            addr_cnt_q, addr_cnt_d;
    logic [2:0]                bank_cnt_q, bank_cnt_d;
    logic [wDRN-1:0]           drn_cnt_q, drn_cnt_d;
    logic [RD_LAT-1:0]         pv_q, pv_d;
    logic [RD_LAT-1:0]         ps_q, ps_d;
    logic [RD_LAT-1:0]         pe_q, pe_d;
    logic [RD_LAT-1:0][2:0]    pb_q, pb_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_sop_q, out_sop_d;
    logic                      out_eop_q, out_eop_d;
    logic [wDATA-1:0]          out_data_q, out_data_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      issue;
    logic                      addr_last;
    logic                      bank_last;
    logic                      rd_last;
    logic [wDATA-1:0]          tail_data;

    assign issue     = (state_q == S_READ);
    assign addr_last = (addr_cnt_q == rows_q - (wADDR+1)'(1));
    assign bank_last = (bank_cnt_q == 3'd6);
    assign rd_last   = addr_last && bank_last;

    assign rden   = issue ? (7'b1000000 >> bank_cnt_q) : 7'b0;
    assign rdaddr = issue ? addr_cnt_q[wADDR-1:0] : '0;

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        mode_d     = mode_q;
        addr_cnt_d = addr_cnt_q;
        bank_cnt_d = bank_cnt_q;
        drn_cnt_d  = drn_cnt_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done_q keeps the done cycle itself closed to a new start
                if (start && (rows != '0) && !done_q) begin
                    state_d    = S_READ;
                    rows_d     = rows;
                    mode_d     = mode;
                    addr_cnt_d = '0;
                    bank_cnt_d = '0;
                end
            end
            S_READ: begin
                if (rd_last) begin
                    state_d    = S_DRAIN;
                    addr_cnt_d = '0;
                    bank_cnt_d = '0;
                    drn_cnt_d  = '0;
                end else if (!mode_q) begin
                    if (bank_last) begin
                        bank_cnt_d = '0;
                        addr_cnt_d = addr_cnt_q + 1'b1;
                    end else begin
                        bank_cnt_d = bank_cnt_q + 1'b1;
                    end
                end else begin
                    if (addr_last) begin
                        addr_cnt_d = '0;
                        bank_cnt_d = bank_cnt_q + 1'b1;
                    end else begin
                        addr_cnt_d = addr_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drn_cnt_q == DRN_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drn_cnt_d = drn_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) || done_d;
    end

    always_comb begin
        pv_d    = pv_q;
        ps_d    = ps_q;
        pe_d    = pe_q;
        pb_d    = pb_q;
        pv_d[0] = issue;
        ps_d[0] = issue && (bank_cnt_q == 3'd0) && (addr_cnt_q == '0);
        pe_d[0] = issue && rd_last;
        pb_d[0] = bank_cnt_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            ps_d[i] = ps_q[i-1];
            pe_d[i] = pe_q[i-1];
            pb_d[i] = pb_q[i-1];
        end
    end

    // The tail of the pipeline lines up with the cycle rddata is valid
    always_comb begin
        tail_data = '0;
        for (int b = 0; b < 7; b++) begin
            if (pb_q[RD_LAT-1] == 3'(b)) tail_data = rddata[b];
        end
        out_valid_d = pv_q[RD_LAT-1];
        out_sop_d   = pv_q[RD_LAT-1] && ps_q[RD_LAT-1];
        out_eop_d   = pv_q[RD_LAT-1] && pe_q[RD_LAT-1];
        out_data_d  = pv_q[RD_LAT-1] ? tail_data : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rows_q      <= '0;
            mode_q      <= 1'b0;
            addr_cnt_q  <= '0;
            bank_cnt_q  <= '0;
            drn_cnt_q   <= '0;
            pv_q        <= '0;
            ps_q        <= '0;
            pe_q        <= '0;
            pb_q        <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            mode_q      <= mode_d;
            addr_cnt_q  <= addr_cnt_d;
            bank_cnt_q  <= bank_cnt_d;
            drn_cnt_q   <= drn_cnt_d;
            pv_q        <= pv_d;
            ps_q        <= ps_d;
            pe_q        <= pe_d;
            pb_q        <= pb_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
